// File: rtl/ysyx_22041461_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_pkg
// Shared definitions for the instruction-fetch stage: data widths, the
// default reset PC, the fetch FSM state encoding and a PC alignment helper.
// ----------------------------------------------------------------------------
package ysyx_22041461_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // StIdle: nothing in flight, may request.
    // StWait: one request in flight, its response will be kept.
    // StDrop: one request in flight, its response will be discarded.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } if_state_e;

    // Instructions are word-aligned; low two bits of any target are forced to 0.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22041461_if_stage_slot.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_IF_slot
// One-entry valid/ready output buffer between fetch and the ID register.
//
// Ports:
//   clk      - clock, state updates on rising edge
//   rst      - synchronous active-low reset
//   i_flush  - discard the held entry (redirect)
//   i_load   - capture i_inst / i_pc as a new valid entry
//   i_inst   - instruction word to capture
//   i_pc     - PC belonging to i_inst
//   i_drain  - downstream accepts the held entry this cycle
//   o_valid  - entry is valid
//   o_inst   - held instruction
//   o_pc     - held PC
// ----------------------------------------------------------------------------
module ysyx_22041461_IF_slot
    import ysyx_22041461_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic [ILEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_drain,
    output logic            o_valid,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [ILEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    // Flush beats load beats drain; a load while draining replaces the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= RESET_PC;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/ysyx_22041461_if_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_if_stage
// Instruction-fetch stage: keeps the fetch PC, issues at most one request to
// instruction memory at a time, and hands returned words to ID through a
// one-entry output slot. Redirects from EX re-target the PC, flush the slot
// and cause any in-flight response to be discarded.
//
// Ports:
//   clk               - clock, state updates on rising edge
//   rst               - synchronous active-low reset
//   IF_redirect_valid - one-cycle redirect request (branch/jump/trap)
//   IF_redirect_pc    - redirect target (low two bits ignored)
//   IF_req_valid      - fetch request to instruction memory
//   IF_req_addr       - fetch address (current PC)
//   IF_req_ready      - memory accepts the request
//   IF_rsp_valid      - memory returns an instruction word
//   IF_rsp_inst       - returned instruction word
//   IF_out_ready      - ID accepts the output slot this cycle
//   IF_valid_out      - output slot holds a valid instruction
//   IF_inst_out       - instruction to ID
//   IF_pc_out         - PC of IF_inst_out
// ----------------------------------------------------------------------------
module ysyx_22041461_if_stage
    import ysyx_22041461_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_redirect_valid,
    input  logic [XLEN-1:0] IF_redirect_pc,
    output logic            IF_req_valid,
    output logic [XLEN-1:0] IF_req_addr,
    input  logic            IF_req_ready,
    input  logic            IF_rsp_valid,
    input  logic [ILEN-1:0] IF_rsp_inst,
    input  logic            IF_out_ready,
    output logic            IF_valid_out,
    output logic [ILEN-1:0] IF_inst_out,
    output logic [XLEN-1:0] IF_pc_out
);

    if_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;

    logic w_slot_valid;
    logic w_slot_free;
    logic w_hs;
    logic w_rsp_done;
    logic w_rsp_load;

    // A new request may only go out when its response has somewhere to land.
    assign w_slot_free  = !w_slot_valid || IF_out_ready;
    assign IF_req_valid = rst && (r_state == StIdle) && w_slot_free;
    assign IF_req_addr  = r_pc;
    assign w_hs         = IF_req_valid && IF_req_ready;

    // Responses only count while something is in flight.
    assign w_rsp_done = IF_rsp_valid && (r_state != StIdle);
    assign w_rsp_load = IF_rsp_valid && (r_state == StWait) && !IF_redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            if (w_hs) begin
                r_req_pc <= r_pc;
            end
            if (IF_redirect_valid) begin
                r_pc <= align_pc(IF_redirect_pc);
                case (r_state)
                    StIdle:  r_state <= w_hs ? StDrop : StIdle;
                    // A response arriving with the redirect closes the old
                    // request; otherwise its response must still be absorbed.
                    StWait,
                    StDrop:  r_state <= w_rsp_done ? StIdle : StDrop;
                    default: r_state <= StIdle;
                endcase
            end else begin
                if (w_hs) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                case (r_state)
                    StIdle:  r_state <= w_hs ? StWait : StIdle;
                    StWait,
                    StDrop:  r_state <= w_rsp_done ? StIdle : r_state;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    ysyx_22041461_IF_slot #(
        .RESET_PC (RESET_PC)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_flush (IF_redirect_valid),
        .i_load  (w_rsp_load),
        .i_inst  (IF_rsp_inst),
        .i_pc    (r_req_pc),
        .i_drain (IF_out_ready),
        .o_valid (w_slot_valid),
        .o_inst  (IF_inst_out),
        .o_pc    (IF_pc_out)
    );

    assign IF_valid_out = w_slot_valid;

endmodule

// File: tb/tb_ysyx_22041461_if_stage.sv
module tb_ysyx_22041461_if_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IF_redirect_valid = 1'b0;
    logic [63:0] IF_redirect_pc = '0;
    logic        IF_req_valid;
    logic [63:0] IF_req_addr;
    logic        IF_req_ready = 1'b0;
    logic        IF_rsp_valid = 1'b0;
    logic [31:0] IF_rsp_inst = '0;
    logic        IF_out_ready = 1'b0;
    logic        IF_valid_out;
    logic [31:0] IF_inst_out;
    logic [63:0] IF_pc_out;

    always #5 clk = ~clk;

    ysyx_22041461_if_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IF_redirect_valid (IF_redirect_valid),
        .IF_redirect_pc    (IF_redirect_pc),
        .IF_req_valid      (IF_req_valid),
        .IF_req_addr       (IF_req_addr),
        .IF_req_ready      (IF_req_ready),
        .IF_rsp_valid      (IF_rsp_valid),
        .IF_rsp_inst       (IF_rsp_inst),
        .IF_out_ready      (IF_out_ready),
        .IF_valid_out      (IF_valid_out),
        .IF_inst_out       (IF_inst_out),
        .IF_pc_out         (IF_pc_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a fetch is live only if no redirect/reset happened
    // since it was issued (epoch tagging). Live words go to the scoreboard.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } out_t;

    out_t        exp_q[$];
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_req_pc = RST_PC;
    bit          m_out = 1'b0;
    bit          m_slot = 1'b0;
    int          m_epoch = 0;
    int          m_tag = 0;

    function automatic bit m_req_valid();
        return (rst === 1'b1) && !m_out && (!m_slot || (IF_out_ready === 1'b1));
    endfunction

    initial begin : model_proc
        out_t e;
        bit   hs;
        bit   live;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_pc   = RST_PC;
                m_out  = 1'b0;
                m_slot = 1'b0;
                exp_q.delete();
                m_epoch++;
            end else begin
                hs   = m_req_valid() && IF_req_ready;
                live = m_out && IF_rsp_valid && (m_tag == m_epoch) && !IF_redirect_valid;
                if (m_out && IF_rsp_valid) m_out = 1'b0;
                if (IF_redirect_valid) begin
                    m_slot = 1'b0;
                    exp_q.delete();
                end else if (live) begin
                    e.inst = IF_rsp_inst;
                    e.pc   = m_req_pc;
                    exp_q.push_back(e);
                    m_slot = 1'b1;
                end else if (IF_out_ready) begin
                    m_slot = 1'b0;
                end
                if (hs) begin
                    m_out    = 1'b1;
                    m_tag    = m_epoch;
                    m_req_pc = m_pc;
                end
                if (IF_redirect_valid) begin
                    m_pc = {IF_redirect_pc[63:2], 2'b00};
                    m_epoch++;
                end else if (hs) begin
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    // Monitor: compares DUT against model away from the rising edge.
    initial begin : monitor_proc
        out_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("req_valid", 64'(IF_req_valid), 64'(m_req_valid()));
            if (m_req_valid()) chk("req_addr", IF_req_addr, m_pc);
            chk("valid_out", 64'(IF_valid_out), 64'(m_slot));
            if (m_slot) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard: got empty queue, expected an entry (t=%0t)", $time);
                end else begin
                    e = exp_q[0];
                    chk("inst_out", 64'(IF_inst_out), 64'(e.inst));
                    chk("pc_out", IF_pc_out, e.pc);
                    if (IF_out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    // Memory responder: answers each accepted request after lat cycles.
    int          lat = 1;
    logic [31:0] rsp_word = 32'h0000_0013;

    initial begin : mem_proc
        bit          hs_seen;
        bit          pending;
        int          cnt;
        int          lat_l;
        logic [31:0] word_l;
        pending = 1'b0;
        cnt     = 0;
        lat_l   = 1;
        word_l  = '0;
        forever begin
            @(negedge clk);
            hs_seen = IF_req_valid && IF_req_ready;
            if (hs_seen) begin
                lat_l  = lat;
                word_l = rsp_word;
            end
            @(posedge clk);
            #1;
            IF_rsp_valid = 1'b0;
            if (hs_seen) begin
                pending = 1'b1;
                cnt     = lat_l - 1;
            end
            if (pending) begin
                if (cnt == 0) begin
                    IF_rsp_valid = 1'b1;
                    IF_rsp_inst  = word_l;
                    pending      = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge and hold for a cycle.
    task automatic step(input bit rr, input bit orr, input bit rd, input logic [63:0] rpc);
        IF_req_ready      = rr;
        IF_out_ready      = orr;
        IF_redirect_valid = rd;
        IF_redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin : driver_proc
        // Reset state
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
        chk("rst_valid_out", 64'(IF_valid_out), 64'd0);
        chk("rst_pc_out", IF_pc_out, RST_PC);
        chk("rst_inst_out", 64'(IF_inst_out), 64'd0);
        chk("rst_req_valid", 64'(IF_req_valid), 64'd0);

        // Memory not ready: request held, PC not advanced
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("stall_req_valid", 64'(IF_req_valid), 64'd1);
            chk("stall_req_addr", IF_req_addr, RST_PC);
        end

        // First fetch, response one cycle later
        lat = 1;
        rsp_word = 32'h0000_0013;
        step(1'b1, 1'b1, 1'b0, '0);
        chk("first_pc_adv", IF_req_addr, 64'h0000_0000_8000_0004);
        chk("first_outstanding", 64'(IF_req_valid), 64'd0);
        rsp_word = $urandom;
        step(1'b1, 1'b1, 1'b0, '0);
        chk("first_valid", 64'(IF_valid_out), 64'd1);
        chk("first_inst", 64'(IF_inst_out), 64'h13);
        chk("first_pc", IF_pc_out, RST_PC);
        chk("second_req_addr", IF_req_addr, 64'h0000_0000_8000_0004);

        // ID stalled for 5 cycles: slot holds, no new request
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            chk("hold_valid", 64'(IF_valid_out), 64'd1);
            chk("hold_inst", 64'(IF_inst_out), 64'h13);
            chk("hold_pc", IF_pc_out, RST_PC);
            chk("hold_no_req", 64'(IF_req_valid), 64'd0);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        settle(4);

        // Redirect while waiting: late response discarded
        lat = 3;
        rsp_word = 32'hDEAD_BEEF;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0100);
        settle(3);
        chk("drop_valid", 64'(IF_valid_out), 64'd0);
        chk("drop_req_valid", 64'(IF_req_valid), 64'd1);
        chk("drop_req_addr", IF_req_addr, 64'h0000_0000_8000_0100);
        lat = 1;
        rsp_word = $urandom;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("redir_valid", 64'(IF_valid_out), 64'd1);
        chk("redir_pc", IF_pc_out, 64'h0000_0000_8000_0100);
        settle(4);

        // Redirect in the same cycle as the response, unaligned target
        lat = 2;
        rsp_word = 32'h1234_5678;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0203);
        chk("coinc_valid", 64'(IF_valid_out), 64'd0);
        chk("coinc_req_valid", 64'(IF_req_valid), 64'd1);
        chk("coinc_req_addr", IF_req_addr, 64'h0000_0000_8000_0200);
        settle(2);

        // Reset while waiting; stale response after release is ignored
        lat = 3;
        rsp_word = 32'hCAFE_F00D;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, '0);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, '0);
        chk("stale_valid", 64'(IF_valid_out), 64'd0);
        chk("stale_req_valid", 64'(IF_req_valid), 64'd1);
        chk("stale_req_addr", IF_req_addr, RST_PC);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("stale_valid2", 64'(IF_valid_out), 64'd0);
        lat = 1;
        rsp_word = $urandom;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("after_rst_pc", IF_pc_out, RST_PC);
        settle(3);

        // PC wraps at the top of the address space
        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_target", IF_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_next", IF_req_addr, 64'd0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_pc_out", IF_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        settle(4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            lat      = 1 + int'($urandom_range(0, 2));
            rsp_word = $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, {$urandom, $urandom});
        end
        settle(6);
        chk("outputs_seen", 64'(n_out > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
